instr_mem_burst_responder: RTL

- Memory-side responder for instruction-cache line fills. While the cache stalls in its allocate phase it holds a read request high.
- This block fetches one full cache line, word by word, from a backing memory over a req/ack port.
- It returns each word as a beat to the cache and flags the final beat with a last strobe.
- It sits between the instruction cache controller and main memory.

---
 rtl/instr_mem_burst_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/instr_mem_burst_responder.sv
// Instruction-cache line-fill responder: fetches one line word by word over a
// req/ack memory port and returns each word as a registered beat.
module instr_mem_burst_responder #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BLOCK_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_start_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [DATA_WIDTH-1:0] o_r_data,
    output logic                  o_r_valid,
    output logic                  o_r_last,
    output logic                  o_busy
);

    localparam int unsigned CntW     = $clog2(BLOCK_WORDS);
    localparam int unsigned ByteW    = DATA_WIDTH / 8;
    localparam int unsigned LineBits = $clog2(BLOCK_WORDS * ByteW);
    localparam logic [ADDR_WIDTH-1:0] LineMask =
        ~((ADDR_WIDTH'(1) << LineBits) - ADDR_WIDTH'(1));
    localparam logic [CntW-1:0] LastCnt = CntW'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StReq, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;
    logic                    r_valid_q, r_valid_d;
    logic                    r_last_q, r_last_d;

    // State and beat registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            base_q    <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
            r_last_q  <= r_last_d;
        end
    end

    // Next-state logic; beat strobes default low so they are single-cycle pulses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        r_data_d  = r_data_q;
        r_valid_d = 1'b0;
        r_last_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_start_read) begin
                    base_d  = i_addr & LineMask;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (!i_start_read) begin
                    // Abort: a completed word is dropped; a pending one must still be drained.
                    state_d = i_mem_ack ? StIdle : StDrain;
                end else if (i_mem_ack) begin
                    r_data_d  = i_mem_rdata;
                    r_valid_d = 1'b1;
                    if (cnt_q == LastCnt) begin
                        r_last_d = 1'b1;
                        state_d  = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (i_mem_ack) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                // Level request still high after the last beat must not start a new burst.
                if (!i_start_read) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_mem_req  = (state_q == StReq) || (state_q == StDrain);
    assign o_mem_addr = base_q + (ADDR_WIDTH'(cnt_q) * ADDR_WIDTH'(ByteW));
    assign o_r_data   = r_data_q;
    assign o_r_valid  = r_valid_q;
    assign o_r_last   = r_last_q;
    assign o_busy     = (state_q != StIdle);

endmodule
